accel_fifo: RTL and testbench

Synchronous single-clock FIFO between the router's data bus controller and one accelerator (FFT, FIR or IIR); two instances per accelerator (router-to-accelerator and accelerator-to-router). It buffers 128-bit words and produces the empty/full status that the data bus controller samples to choose transfer direction. Write side faces the producer (router or accelerator). Read side faces the consumer, with a registered data output.

---
 rtl/accel_fifo.sv | 102 ++++++++++
 tb/tb_accel_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_fifo.sv
// Single-clock FIFO between the router's data bus controller and one accelerator.
// Registered read data; status flags are decoded from registered pointers only.
module accel_fifo #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              rd_accept;
    logic              wr_accept;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[ADDR_W-1:0];
    assign rd_idx = rd_ptr_q[ADDR_W-1:0];

    // Wrap bits differ with equal index bits means the write side has lapped the read side.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A read on the same edge frees a slot, so a full FIFO still accepts the write.
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_en & (~full | rd_accept);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_accept;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + PtrOne;
            rd_data_d = mem_q[rd_idx];
        end
        if (wr_en && full && !rd_accept) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_accel_fifo.sv
// Directed self-checking bench for accel_fifo: reset, fill/drain, full-simultaneous,
// wrap-around, empty-simultaneous and mid-stream reset.
module tb_accel_fifo;

    localparam int unsigned WIDTH  = 128;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    accel_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus, then settle just past the rising edge.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 128'hDEAD, 1'b1);
            checks++;
            if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
                errors++;
                $display("FAIL reset_flags e=%b f=%b c=%0d want e=1 f=0 c=0", empty, full, count);
            end
            checks++;
            if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0
                || rd_data !== '0) begin
                errors++;
                $display("FAIL reset_outs v=%b o=%b u=%b d=%h want all 0",
                         rd_valid, overflow, underflow, rd_data);
            end
        end
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle e=%b c=%0d want e=1 c=0", empty, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0);
            checks++;
            if (count !== 4'(i) || full !== (i == 8) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d c=%0d f=%b e=%b want c=%0d f=%b e=0",
                         i, count, full, empty, i, (i == 8));
            end
        end
        cycle(1'b1, WIDTH'(9), 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow o=%b c=%0d f=%b want o=1 c=8 f=1", overflow, count, full);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== WIDTH'(i) || count !== 4'(8 - i)) begin
                errors++;
                $display("FAIL drain_%0d v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         i, rd_valid, rd_data, count, WIDTH'(i), 8 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty e=%b u=%b want e=1 u=0", empty, underflow);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || rd_data !== WIDTH'(8)) begin
            errors++;
            $display("FAIL drain_underflow v=%b u=%b d=%h want v=0 u=1 d=8",
                     rd_valid, underflow, rd_data);
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, WIDTH'(i), 1'b0);
        cycle(1'b1, WIDTH'(10), 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== WIDTH'(1) || count !== 4'd8
            || full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_simul v=%b d=%h c=%0d f=%b o=%b want v=1 d=1 c=8 f=1 o=0",
                     rd_valid, rd_data, count, full, overflow);
        end
        for (int i = 2; i <= 9; i++) begin
            automatic logic [WIDTH-1:0] exp = (i == 9) ? WIDTH'(10) : WIDTH'(i);
            cycle(1'b0, '0, 1'b1);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL full_drain_%0d v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drain_empty e=%b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, WIDTH'(103 + i), 1'b1);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== WIDTH'(100 + i) || count !== 4'd3) begin
                errors++;
                $display("FAIL wrap_%0d v=%b d=%h c=%0d want v=1 d=%h c=3",
                         i, rd_valid, rd_data, count, WIDTH'(100 + i));
            end
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_sticky o=%b u=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        cycle(1'b1, 128'h55, 1'b1);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || count !== 4'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_simul v=%b u=%b c=%0d e=%b want v=0 u=1 c=1 e=0",
                     rd_valid, underflow, count, empty);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 128'h55) begin
            errors++;
            $display("FAIL empty_simul_read v=%b d=%h want v=1 d=55", rd_valid, rd_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 9; i++) cycle(1'b1, WIDTH'(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup c=%0d o=%b want c=5 o=1", count, overflow);
        end
        rst_n = 1'b0;
        cycle(1'b1, 128'h77, 1'b1);
        rst_n = 1'b1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0
            || rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_reset c=%0d e=%b o=%b u=%b v=%b d=%h want 0 1 0 0 0 0",
                     count, empty, overflow, underflow, rd_valid, rd_data);
        end
        cycle(1'b1, 128'hBEEF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 128'hBEEF || empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_beef v=%b d=%h e=%b want v=1 d=beef e=1", rd_valid, rd_data, empty);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_wrap();
        test_empty_simul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
